btrm_loader: RTL

- Boot image writer feeding the bootrom write port (wen/din/address): receives a byte stream from the debug/UART link, assembles little-endian 32-bit instruction words and issues one write per word at consecutive word addresses starting at 0.
- Holds the core in reset (`hold_core`) while loading; releases it on successful completion.
- Sits between the serial byte receiver and the bootrom.

---
 rtl/btrm_loader_if.sv | 14 +
 rtl/btrm_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/btrm_loader_if.sv
// Byte-stream intake and bootrom write port of the boot image loader.
interface btrm_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        byte_data;
  logic              byte_vld;
  logic              byte_rdy;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output byte_data, byte_vld, input byte_rdy, wen, waddr, wdata);
  modport slave  (input byte_data, byte_vld, output byte_rdy, wen, waddr, wdata);
endinterface

// File: rtl/btrm_loader.sv
// Boot image loader: LE length word, then LE instruction words written to bootrom from address 0.
// Optional trailing 32-bit checksum stage enabled by BTRM_LOADER_CHKSUM_EN.
module btrm_loader #(
  parameter int RAM_DEPTH = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  btrm_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          hold_core
);

  if (ADDR_W != $clog2(RAM_DEPTH)) begin : g_bad_addr_w
    $error("btrm_loader: ADDR_W must equal clog2(RAM_DEPTH)");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WR, S_CHK, S_FIN} state_t;

  state_t            state;
  logic [1:0]        bcnt;
  logic [31:0]       shreg;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] wcnt;
`ifdef BTRM_LOADER_CHKSUM_EN
  logic [31:0]       csum;
`endif

  logic        xfer;
  logic        last_byte;
  logic [31:0] asm_word;
  logic        last_word;

  // Bytes shift in from the top so the first byte lands in [7:0] after four.
  assign xfer      = bus.byte_vld & bus.byte_rdy;
  assign last_byte = xfer && (bcnt == 2'd3);
  assign asm_word  = {bus.byte_data, shreg[31:8]};
  assign last_word = (({1'b0, wcnt} + 1'b1) == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bcnt         <= '0;
      shreg        <= '0;
      len          <= '0;
      wcnt         <= '0;
`ifdef BTRM_LOADER_CHKSUM_EN
      csum         <= '0;
`endif
      bus.byte_rdy <= 1'b0;
      bus.wen      <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      hold_core    <= 1'b1;
    end else begin
      bus.wen <= 1'b0;
      if (xfer) begin
        shreg <= asm_word;
        bcnt  <= bcnt + 2'd1;
      end
      case (state)
        S_IDLE: if (start) begin
          state        <= S_LEN;
          bus.byte_rdy <= 1'b1;
          busy         <= 1'b1;
          hold_core    <= 1'b1;
          done         <= 1'b0;
          err          <= 1'b0;
          wcnt         <= '0;
          bcnt         <= '0;
`ifdef BTRM_LOADER_CHKSUM_EN
          csum         <= '0;
`endif
        end
        S_LEN: if (last_byte) begin
          if (asm_word == 32'd0) begin
`ifdef BTRM_LOADER_CHKSUM_EN
            state        <= S_CHK;
`else
            state        <= S_FIN;
            bus.byte_rdy <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            hold_core    <= 1'b0;
`endif
          end else if ({1'b0, asm_word} > 33'(RAM_DEPTH)) begin
            state        <= S_FIN;
            bus.byte_rdy <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else begin
            len   <= asm_word[ADDR_W:0];
            state <= S_DATA;
          end
        end
        S_DATA: if (last_byte) begin
          state        <= S_WR;
          bus.byte_rdy <= 1'b0;
          bus.wen      <= 1'b1;
          bus.waddr    <= wcnt;
          bus.wdata    <= asm_word;
        end
        S_WR: begin
          // Counter may wrap only on the final word of a full-depth image; it is not used afterwards.
          wcnt <= wcnt + 1'b1;
`ifdef BTRM_LOADER_CHKSUM_EN
          csum <= csum + bus.wdata;
`endif
          if (last_word) begin
`ifdef BTRM_LOADER_CHKSUM_EN
            state        <= S_CHK;
            bus.byte_rdy <= 1'b1;
`else
            state        <= S_FIN;
            busy         <= 1'b0;
            done         <= 1'b1;
            hold_core    <= 1'b0;
`endif
          end else begin
            state        <= S_DATA;
            bus.byte_rdy <= 1'b1;
          end
        end
`ifdef BTRM_LOADER_CHKSUM_EN
        S_CHK: if (last_byte) begin
          state        <= S_FIN;
          bus.byte_rdy <= 1'b0;
          busy         <= 1'b0;
          if (asm_word == csum) begin
            done      <= 1'b1;
            hold_core <= 1'b0;
          end else begin
            err       <= 1'b1;
          end
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
